// File: rtl/fwd_hazard_track.sv
// Shadow EX/MEM/WB destination tags, forwarding equality flags and stall.
// Optional HAZARD_STATS_EN adds stall/load-use counters with stats_clr.
module fwd_hazard_track #(
  parameter int RW        = 5,
  parameter int NREG_ZERO = 0
) (
  input  logic          clk,
  input  logic          rst,
`ifdef HAZARD_STATS_EN
  input  logic          stats_clr,
  output logic [31:0]   stall_cycles,
  output logic [15:0]   loaduse_events,
`endif
  input  logic          hold,
  input  logic          flush,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_rs_use,
  input  logic          id_rt_use,
  input  logic [RW-1:0] id_dst,
  input  logic          id_regwr,
  input  logic          id_load,
  input  logic          id_branch,
  output logic          stall,
  output logic          idsrc1ex,
  output logic          idsrc1mem,
  output logic          rfd2alueq,
  output logic          rfd2dmbeq,
  output logic          aluaeq,
  output logic          memaeq,
  output logic          alubeq,
  output logic          membeq
);

  localparam logic [RW-1:0] ZR = RW'(NREG_ZERO);

  typedef struct packed {
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          rs_use;
    logic          rt_use;
    logic [RW-1:0] dst;
    logic          regwr;
    logic          load;
  } ex_t;

  typedef struct packed {
    logic [RW-1:0] dst;
    logic          regwr;
    logic          load;
  } mem_t;

  typedef struct packed {
    logic [RW-1:0] dst;
    logic          regwr;
  } wb_t;

  ex_t  ex_q, ex_d;
  mem_t mem_q, mem_d;
  wb_t  wb_q, wb_d;

  function automatic logic hit(
    input logic          rw,
    input logic [RW-1:0] dst,
    input logic [RW-1:0] src,
    input logic          use_b
  );
    return rw && (dst != ZR) && (dst == src) && use_b;
  endfunction

  logic ex_hit_id, mem_hit_id;
  logic loaduse, br_alu, br_load;

  always_comb begin
    idsrc1ex  = hit(mem_q.regwr, mem_q.dst, id_rs, id_rs_use);
    idsrc1mem = hit(wb_q.regwr, wb_q.dst, id_rs, id_rs_use);
    rfd2alueq = hit(mem_q.regwr, mem_q.dst, id_rt, id_rt_use);
    rfd2dmbeq = hit(wb_q.regwr, wb_q.dst, id_rt, id_rt_use);
    aluaeq    = hit(mem_q.regwr, mem_q.dst, ex_q.rs, ex_q.rs_use);
    memaeq    = hit(wb_q.regwr, wb_q.dst, ex_q.rs, ex_q.rs_use);
    alubeq    = hit(mem_q.regwr, mem_q.dst, ex_q.rt, ex_q.rt_use);
    membeq    = hit(wb_q.regwr, wb_q.dst, ex_q.rt, ex_q.rt_use);
  end

  // ID source matching against the producer still in EX or MEM
  always_comb begin
    ex_hit_id  = hit(ex_q.regwr, ex_q.dst, id_rs, id_rs_use) ||
                 hit(ex_q.regwr, ex_q.dst, id_rt, id_rt_use);
    mem_hit_id = idsrc1ex || rfd2alueq;
    loaduse    = ex_q.load && ex_hit_id;
    br_alu     = id_branch && ex_hit_id;
    br_load    = id_branch && mem_q.load && mem_hit_id;
    stall      = loaduse || br_alu || br_load;
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!hold) begin
      wb_d  = '{dst: mem_q.dst, regwr: mem_q.regwr};
      mem_d = '{dst: ex_q.dst, regwr: ex_q.regwr, load: ex_q.load};
      if (flush || stall) begin
        ex_d = '0;
      end else begin
        ex_d = '{rs: id_rs, rt: id_rt,
                 rs_use: id_rs_use, rt_use: id_rt_use,
                 dst: id_dst, regwr: id_regwr, load: id_load};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] sc_q, sc_d;
  logic [15:0] le_q, le_d;
  logic        lu_q;

  always_comb begin
    sc_d = sc_q;
    le_d = le_q;
    if (stats_clr) begin
      sc_d = '0;
      le_d = '0;
    end else begin
      if (stall && !hold && sc_q != '1) sc_d = sc_q + 32'd1;
      if (loaduse && !lu_q && le_q != '1) le_d = le_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= '0;
      le_q <= '0;
      lu_q <= 1'b0;
    end else begin
      sc_q <= sc_d;
      le_q <= le_d;
      lu_q <= loaduse;
    end
  end

  assign stall_cycles   = sc_q;
  assign loaduse_events = le_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_track.sv
// Directed vector bench for fwd_hazard_track.
// Counter checks compile in when HAZARD_STATS_EN is defined.
module tb_fwd_hazard_track;

  logic       clk = 1'b0;
  logic       rst, hold, flush;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_rs_use, id_rt_use, id_regwr, id_load, id_branch;
  logic       stall, idsrc1ex, idsrc1mem, rfd2alueq, rfd2dmbeq;
  logic       aluaeq, memaeq, alubeq, membeq;
`ifdef HAZARD_STATS_EN
  logic        stats_clr;
  logic [31:0] stall_cycles;
  logic [15:0] loaduse_events;
`endif

  always #5 clk = ~clk;

  fwd_hazard_track #(.RW(5), .NREG_ZERO(0)) dut (
    .clk(clk), .rst(rst),
`ifdef HAZARD_STATS_EN
    .stats_clr(stats_clr),
    .stall_cycles(stall_cycles),
    .loaduse_events(loaduse_events),
`endif
    .hold(hold), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_use(id_rs_use), .id_rt_use(id_rt_use),
    .id_dst(id_dst), .id_regwr(id_regwr),
    .id_load(id_load), .id_branch(id_branch),
    .stall(stall), .idsrc1ex(idsrc1ex), .idsrc1mem(idsrc1mem),
    .rfd2alueq(rfd2alueq), .rfd2dmbeq(rfd2dmbeq),
    .aluaeq(aluaeq), .memaeq(memaeq),
    .alubeq(alubeq), .membeq(membeq)
  );

  localparam logic [8:0] S   = 9'h100;
  localparam logic [8:0] I1E = 9'h080;
  localparam logic [8:0] I1M = 9'h040;
  localparam logic [8:0] RAE = 9'h020;
  localparam logic [8:0] RDM = 9'h010;
  localparam logic [8:0] AA  = 9'h008;
  localparam logic [8:0] MA  = 9'h004;
  localparam logic [8:0] AB  = 9'h002;
  localparam logic [8:0] MB  = 9'h001;

  typedef struct {
    logic       r, h, f;
    logic [4:0] rs, rt;
    logic       rsu, rtu;
    logic [4:0] d;
    logic       w, l, b;
    logic [8:0] e;
    logic       lu;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   failures = 0;
  int   m_sc = 0;
  int   m_le = 0;
  logic m_prev = 1'b0;

  task automatic add(
    input logic r, h, f,
    input logic [4:0] rs, rt,
    input logic rsu, rtu,
    input logic [4:0] d,
    input logic w, l, b,
    input logic [8:0] e,
    input logic lu
  );
    vec_t v;
    v = '{r:r, h:h, f:f, rs:rs, rt:rt, rsu:rsu, rtu:rtu,
          d:d, w:w, l:l, b:b, e:e, lu:lu};
    tv.push_back(v);
  endtask

  task automatic nop();
    add(0,0,0, 0,0, 0,0, 0, 0,0,0, 9'h000, 0);
  endtask

  task automatic drive(input vec_t v);
    rst = v.r; hold = v.h; flush = v.f;
    id_rs = v.rs; id_rt = v.rt;
    id_rs_use = v.rsu; id_rt_use = v.rtu;
    id_dst = v.d; id_regwr = v.w;
    id_load = v.l; id_branch = v.b;
  endtask

  function automatic logic [8:0] obs();
    return {stall, idsrc1ex, idsrc1mem, rfd2alueq, rfd2dmbeq,
            aluaeq, memaeq, alubeq, membeq};
  endfunction

  task automatic chk_flags(input string nm, input logic [8:0] want);
    checks++;
    if (obs() !== want) begin
      failures++;
      $display("FAIL %s flags got=%b want=%b", nm, obs(), want);
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic chk_cnt(input string nm, input int sc, input int le);
    checks++;
    if (stall_cycles !== 32'(sc) || loaduse_events !== 16'(le)) begin
      failures++;
      $display("FAIL %s counters got=%0d/%0d want=%0d/%0d",
               nm, stall_cycles, loaduse_events, sc, le);
    end
  endtask
`endif

  initial begin
    vec_t z;
    z = '{r:1, h:0, f:0, rs:0, rt:0, rsu:0, rtu:0,
          d:0, w:0, l:0, b:0, e:0, lu:0};
    drive(z);
`ifdef HAZARD_STATS_EN
    stats_clr = 1'b0;
`endif

    // reset, ALU->ALU forwarding
    add(1,0,0, 3,5, 1,1, 7, 1,1,1, 9'h000, 0);
    nop();
    add(0,0,0, 0,0, 0,0, 3, 1,0,0, 9'h000, 0);
    add(0,0,0, 3,0, 1,0, 4, 1,0,0, 9'h000, 0);
    add(0,0,0, 3,0, 1,0, 6, 1,0,0, I1E|AA, 0);
    add(0,0,0, 0,0, 0,0, 0, 0,0,0, MA, 0);
    nop(); nop();
    // load-use on rt
    add(0,0,0, 0,0, 0,0, 5, 1,1,0, 9'h000, 0);
    add(0,0,0, 0,5, 0,1, 8, 1,0,0, S, 1);
    add(0,0,0, 0,5, 0,1, 8, 1,0,0, RAE, 0);
    add(0,0,0, 0,0, 0,0, 0, 0,0,0, MB, 0);
    nop(); nop();
    // load then dependent branch
    add(0,0,0, 0,0, 0,0, 7, 1,1,0, 9'h000, 0);
    add(0,0,0, 7,0, 1,0, 0, 0,0,1, S, 1);
    add(0,0,0, 7,0, 1,0, 0, 0,0,1, S|I1E, 0);
    add(0,0,0, 7,0, 1,0, 0, 0,0,1, I1M, 0);
    nop(); nop();
    // ALU then dependent branch
    add(0,0,0, 0,0, 0,0, 9, 1,0,0, 9'h000, 0);
    add(0,0,0, 0,9, 0,1, 0, 0,0,1, S, 0);
    add(0,0,0, 0,9, 0,1, 0, 0,0,1, RAE, 0);
    add(0,0,0, 0,0, 0,0, 0, 0,0,0, MB, 0);
    nop();
    // r0 never matches
    add(0,0,0, 0,0, 0,0, 0, 1,1,0, 9'h000, 0);
    add(0,0,0, 0,0, 1,1, 0, 0,0,1, 9'h000, 0);
    add(0,0,0, 0,0, 1,0, 0, 0,0,1, 9'h000, 0);
    add(0,0,0, 0,0, 1,1, 0, 0,0,0, 9'h000, 0);
    nop(); nop();
    // hold during load-use stall
    add(0,0,0, 0,0, 0,0, 10, 1,1,0, 9'h000, 0);
    add(0,1,0, 10,0, 1,0, 11, 1,0,0, S, 1);
    add(0,1,0, 10,0, 1,0, 11, 1,0,0, S, 1);
    add(0,1,0, 10,0, 1,0, 11, 1,0,0, S, 1);
    add(0,0,0, 10,0, 1,0, 11, 1,0,0, S, 1);
    add(0,0,0, 10,0, 1,0, 11, 1,0,0, I1E, 0);
    add(0,0,0, 0,0, 0,0, 0, 0,0,0, MA, 0);
    nop(); nop();
    // flush with load-use stall
    add(0,0,0, 0,0, 0,0, 12, 1,1,0, 9'h000, 0);
    add(0,0,1, 0,12, 0,1, 13, 1,0,0, S, 1);
    add(0,0,0, 0,12, 0,1, 0, 0,0,0, RAE, 0);
    add(0,0,0, 0,0, 0,0, 0, 0,0,0, MB, 0);
    nop();
    // reset mid-stall
    add(0,0,0, 0,0, 0,0, 14, 1,1,0, 9'h000, 0);
    add(1,0,0, 14,0, 1,0, 0, 0,0,0, S, 1);
    add(0,0,0, 14,0, 1,0, 0, 0,0,0, 9'h000, 0);
    nop();

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
`ifdef HAZARD_STATS_EN
      chk_cnt($sformatf("vec%0d_cnt", i), m_sc, m_le);
`endif
      drive(tv[i]);
      #1;
      chk_flags($sformatf("vec%0d", i), tv[i].e);
      if (tv[i].r) begin
        m_sc = 0; m_le = 0; m_prev = 1'b0;
      end else begin
        if (tv[i].e[8] && !tv[i].h) m_sc++;
        if (tv[i].lu && !m_prev) m_le++;
        m_prev = tv[i].lu;
      end
      @(negedge clk);
    end

    // load-use stall coinciding with stats_clr
    drive('{r:0, h:0, f:0, rs:0, rt:0, rsu:0, rtu:0,
            d:15, w:1, l:1, b:0, e:0, lu:0});
    @(negedge clk);
    drive('{r:0, h:0, f:0, rs:0, rt:15, rsu:0, rtu:1,
            d:0, w:0, l:0, b:0, e:0, lu:0});
`ifdef HAZARD_STATS_EN
    stats_clr = 1'b1;
`endif
    #1;
    chk_flags("clr_stall", S);
    @(negedge clk);
`ifdef HAZARD_STATS_EN
    chk_cnt("clr_discard", 0, 0);
    stats_clr = 1'b0;
`endif
    #1;
    chk_flags("clr_release", RAE);
    @(negedge clk);
    drive('{r:0, h:0, f:0, rs:0, rt:0, rsu:0, rtu:0,
            d:16, w:1, l:1, b:0, e:0, lu:0});
    @(negedge clk);
    drive('{r:0, h:0, f:0, rs:16, rt:0, rsu:1, rtu:0,
            d:0, w:0, l:0, b:0, e:0, lu:0});
    #1;
    chk_flags("post_clr_stall", S);
    @(negedge clk);
`ifdef HAZARD_STATS_EN
    chk_cnt("post_clr_count", 1, 1);
`endif
    #1;
    chk_flags("post_clr_release", I1E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
